// File: rtl/sop_edge_counter.sv
// sop_edge_counter
// Consumes the two outputs of the dual AND-OR gate block: synchronises them,
// turns rising edges into one-cycle pulses, keeps saturating per-channel and
// coincidence event counts, and offers an atomic req/ack snapshot to a host.
module sop_edge_counter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CLR_ON_SNAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p1y,
    input  logic             p2y,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             p1_rise,
    output logic             p2_rise,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_p1,
    output logic [CNT_W-1:0] snap_p2,
    output logic [CNT_W-1:0] snap_both,
    output logic [2:0]       snap_ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_p1;
    logic [SYNC_STAGES-1:0] sync_p2;
    logic                   d_p1;
    logic                   d_p2;
    logic                   rise_c1;
    logic                   rise_c2;
    logic [2:0]             inc;
    logic [CNT_W-1:0]       cnt [3];
    logic [2:0]             ovf;
    state_t                 state;
    state_t                 state_next;
    logic                   capture;
    logic                   clr_now;

    // Synchroniser chains plus one history flop per channel; the history flop
    // lets a level held high produce only a single rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
            d_p1    <= 1'b0;
            d_p2    <= 1'b0;
        end else begin
            sync_p1 <= {sync_p1[SYNC_STAGES-2:0], p1y};
            sync_p2 <= {sync_p2[SYNC_STAGES-2:0], p2y};
            d_p1    <= sync_p1[SYNC_STAGES-1];
            d_p2    <= sync_p2[SYNC_STAGES-1];
        end
    end

    assign rise_c1 = sync_p1[SYNC_STAGES-1] & ~d_p1;
    assign rise_c2 = sync_p2[SYNC_STAGES-1] & ~d_p2;
    assign inc     = {rise_c1 & rise_c2, rise_c2, rise_c1};

    // Registered rise pulses, aligned with the counter update edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_rise <= 1'b0;
            p2_rise <= 1'b0;
        end else begin
            p1_rise <= rise_c1;
            p2_rise <= rise_c2;
        end
    end

    assign clr_now = capture && (CLR_ON_SNAP != 0);

    // Saturating counters with sticky overflow; a clearing capture reloads a
    // counter with 1 when an event lands on the capture edge so none is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clr_now) begin
                    cnt[i] <= inc[i] ? CNT_ONE : '0;
                    ovf[i] <= inc[i] && (cnt[i] == CNT_MAX);
                end else if (inc[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    // Snapshot registers take the pre-edge counts on capture and stay frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_p1   <= '0;
            snap_p2   <= '0;
            snap_both <= '0;
            snap_ovf  <= '0;
        end else if (capture) begin
            snap_p1   <= cnt[0];
            snap_p2   <= cnt[1];
            snap_both <= cnt[2];
            snap_ovf  <= ovf;
        end
    end

    // Snapshot FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a request in IDLE captures, an ack in HOLD releases; in HOLD
    // any concurrent request is dropped so the host must ask again from IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (snap_req) state_next = HOLD;
            HOLD: if (snap_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: capture strobe and the valid flag seen by the host.
    always_comb begin
        capture    = 1'b0;
        snap_valid = 1'b0;
        case (state)
            IDLE: capture    = snap_req;
            HOLD: snap_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sop_edge_counter.sv
// tb_sop_edge_counter
// Drives gate-output pulses into a 4-bit-counter instance, models the expected
// counts, queues expected snapshots on each request and compares them when
// the snapshot becomes valid.
module tb_sop_edge_counter;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             p1y;
    logic             p2y;
    logic             snap_req;
    logic             snap_ack;
    logic             p1_rise;
    logic             p2_rise;
    logic             snap_valid;
    logic [CNT_W-1:0] snap_p1;
    logic [CNT_W-1:0] snap_p2;
    logic [CNT_W-1:0] snap_both;
    logic [2:0]       snap_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model of the live counters
    int         m_p1   = 0;
    int         m_p2   = 0;
    int         m_both = 0;
    logic [2:0] m_ovf  = 3'b000;

    // Expected snapshots: {ovf, both, p2, p1}
    logic [14:0] exp_q [$];

    int p1_pulses = 0;
    int p2_pulses = 0;

    sop_edge_counter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .CLR_ON_SNAP(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p1y       (p1y),
        .p2y       (p2y),
        .snap_req  (snap_req),
        .snap_ack  (snap_ack),
        .p1_rise   (p1_rise),
        .p2_rise   (p2_rise),
        .snap_valid(snap_valid),
        .snap_p1   (snap_p1),
        .snap_p2   (snap_p2),
        .snap_both (snap_both),
        .snap_ovf  (snap_ovf)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rise pulses on the inactive edge.
    always @(negedge clk) begin
        if (p1_rise === 1'b1) p1_pulses++;
        if (p2_rise === 1'b1) p2_pulses++;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bump(inout int cnt, inout logic [2:0] ovf, input int bitpos);
        if (cnt == 15) ovf[bitpos] = 1'b1;
        else cnt++;
    endtask

    // One pulse on the selected channels, high for hi cycles then low for 4.
    task automatic pulse(input bit a, input bit b, input int hi);
        p1y = a;
        p2y = b;
        repeat (hi) tick();
        p1y = 1'b0;
        p2y = 1'b0;
        repeat (4) tick();
        if (a) bump(m_p1, m_ovf, 0);
        if (b) bump(m_p2, m_ovf, 1);
        if (a && b) bump(m_both, m_ovf, 2);
    endtask

    // Request a snapshot, expect it one edge later, then acknowledge it.
    task automatic do_snap(input string name);
        logic [14:0] exp;
        int          n;
        snap_req = 1'b1;
        exp_q.push_back({m_ovf, 4'(m_both), 4'(m_p2), 4'(m_p1)});
        m_p1   = 0;
        m_p2   = 0;
        m_both = 0;
        m_ovf  = 3'b000;
        tick();
        snap_req = 1'b0;
        n = 0;
        while (snap_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (n != 0) begin
            errors++;
            $display("[TB] FAIL %s valid_latency got %0d extra cycles expected 0", name, n);
        end
        checks++;
        if (snap_p1 !== exp[3:0]) begin
            errors++;
            $display("[TB] FAIL %s snap_p1 got %0d expected %0d", name, snap_p1, exp[3:0]);
        end
        checks++;
        if (snap_p2 !== exp[7:4]) begin
            errors++;
            $display("[TB] FAIL %s snap_p2 got %0d expected %0d", name, snap_p2, exp[7:4]);
        end
        checks++;
        if (snap_both !== exp[11:8]) begin
            errors++;
            $display("[TB] FAIL %s snap_both got %0d expected %0d", name, snap_both, exp[11:8]);
        end
        checks++;
        if (snap_ovf !== exp[14:12]) begin
            errors++;
            $display("[TB] FAIL %s snap_ovf got %b expected %b", name, snap_ovf, exp[14:12]);
        end
        snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s valid_after_ack got %b expected 0", name, snap_valid);
        end
        checks++;
        if (snap_p1 !== exp[3:0]) begin
            errors++;
            $display("[TB] FAIL %s retain_p1 got %0d expected %0d", name, snap_p1, exp[3:0]);
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_rise;
        repeat (2) tick();
        checks++;
        if ({snap_valid, p1_rise, p2_rise, snap_p1, snap_p2, snap_both, snap_ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_idle outputs got nonzero expected all 0");
        end
        rst_n = 1'b1;
        tick();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if (snap_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hold_valid got %b expected 1", snap_valid);
        end
        p1y = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({snap_valid, p1_rise, p2_rise, snap_p1, snap_p2, snap_both, snap_ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_midhold outputs got valid=%b rise=%b expected all 0", snap_valid, p1_rise);
        end
        tick();
        tick();
        rst_n = 1'b1;
        exp_rise = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (p1_rise !== exp_rise[i]) begin
                errors++;
                $display("[TB] FAIL reset_rise_cycle%0d got %b expected %b", i + 1, p1_rise, exp_rise[i]);
            end
        end
        p1y = 1'b0;
        repeat (4) tick();
        m_p1 = 1;
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid_after got %b expected 0", snap_valid);
        end
        do_snap("reset_snap");
    endtask

    task automatic test_counts;
        int b1;
        int b2;
        b1 = p1_pulses;
        b2 = p2_pulses;
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 4);
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1, 4);
        checks++;
        if (p1_pulses - b1 != 3) begin
            errors++;
            $display("[TB] FAIL counts_p1_pulses got %0d expected 3", p1_pulses - b1);
        end
        checks++;
        if (p2_pulses - b2 != 2) begin
            errors++;
            $display("[TB] FAIL counts_p2_pulses got %0d expected 2", p2_pulses - b2);
        end
        do_snap("counts_snap");
        do_snap("counts_cleared");
    endtask

    task automatic test_coincident;
        int b1;
        int b2;
        b1 = p1_pulses;
        b2 = p2_pulses;
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b1, 4);
        checks++;
        if (p1_pulses - b1 != 5 || p2_pulses - b2 != 5) begin
            errors++;
            $display("[TB] FAIL coinc_pulses got %0d/%0d expected 5/5", p1_pulses - b1, p2_pulses - b2);
        end
        do_snap("coinc_snap");
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 17; i++) pulse(1'b1, 1'b0, 2);
        do_snap("sat_snap");
        do_snap("sat_cleared");
    endtask

    task automatic test_clear_race;
        pulse(1'b0, 1'b1, 2);
        pulse(1'b0, 1'b1, 2);
        p2y = 1'b1;
        tick();
        tick();
        do_snap("race_snap");
        m_p2 = 1;
        p2y = 1'b0;
        repeat (4) tick();
        do_snap("race_second");
    endtask

    task automatic test_back_to_back;
        logic [14:0] exp;
        pulse(1'b1, 1'b0, 2);
        pulse(1'b1, 1'b0, 2);
        snap_req = 1'b1;
        exp_q.push_back({m_ovf, 4'(m_both), 4'(m_p2), 4'(m_p1)});
        m_p1 = 0;
        m_p2 = 0;
        m_both = 0;
        m_ovf = 3'b000;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (snap_valid !== 1'b1 || snap_p1 !== exp[3:0]) begin
            errors++;
            $display("[TB] FAIL b2b_capture got valid=%b p1=%0d expected 1/%0d", snap_valid, snap_p1, exp[3:0]);
        end
        pulse(1'b1, 1'b0, 2);
        checks++;
        if (snap_valid !== 1'b1 || snap_p1 !== exp[3:0]) begin
            errors++;
            $display("[TB] FAIL b2b_frozen got valid=%b p1=%0d expected 1/%0d", snap_valid, snap_p1, exp[3:0]);
        end
        snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
        snap_req = 1'b0;
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ack_release got %b expected 0", snap_valid);
        end
        snap_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (snap_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_no_recapture cycle%0d got %b expected 0", i, snap_valid);
            end
        end
        snap_ack = 1'b0;
        do_snap("b2b_resnap");
    endtask

    // Test sequence.
    initial begin
        rst_n    = 1'b0;
        p1y      = 1'b0;
        p2y      = 1'b0;
        snap_req = 1'b0;
        snap_ack = 1'b0;
        test_reset();
        test_counts();
        test_coincident();
        test_saturation();
        test_clear_race();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sop_edge_counter.md
Name: sop_edge_counter

Overview:
- Downstream consumer of the dual AND-OR (7458-style) gate block.
- Synchronises the two gate outputs p1y/p2y into the clock domain and detects their rising edges.
- Keeps saturating event counts per channel, plus a coincidence count for rises on both channels in the same cycle.
- Exposes a request/acknowledge snapshot interface so a host can read all counts atomically, with optional clear-on-read.

Parameters:
- CNT_W, 8, width of each event counter and snapshot field.
- SYNC_STAGES, 2, flops in each input synchroniser; legal range 2..4.
- CLR_ON_SNAP, 1, when 1 a snapshot capture also clears the live counters and overflow flags.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- p1y  input  1  gate output, channel 1; asynchronous to clk.
- p2y  input  1  gate output, channel 2; asynchronous to clk.
- snap_req  input  1  host request to capture a snapshot.
- snap_ack  input  1  host acknowledge; releases the held snapshot.
- p1_rise  output  1  one-cycle pulse per detected rise on channel 1.
- p2_rise  output  1  one-cycle pulse per detected rise on channel 2.
- snap_valid  output  1  snapshot registers hold valid data.
- snap_p1  output  CNT_W  captured channel-1 count.
- snap_p2  output  CNT_W  captured channel-2 count.
- snap_both  output  CNT_W  captured coincidence count.
- snap_ovf  output  3  captured sticky overflow flags: bit0 = p1, bit1 = p2, bit2 = both.

Behaviour:
- Reset: rst_n low asynchronously clears every flop, including synchronisers, edge history, counters, overflow flags, snapshot registers and FSM state. All outputs read 0; FSM is IDLE. Reset mid-snapshot discards the snapshot; snap_valid drops immediately.
- Synchroniser: SYNC_STAGES-deep flop chain per channel, reset to 0. The last stage feeds a delay flop s_d.
- Edge detect: rise_c = s_last & ~s_d.
  - p1_rise/p2_rise are registered copies of rise_c.
  - Input high before edge k => rise_c true after edge k+SYNC_STAGES-1 => pulse high for exactly the cycle after edge k+SYNC_STAGES.
  - A level held high gives exactly one pulse. A high pulse shorter than one clk period may be missed; this is legal.
- Counters: cnt_p1, cnt_p2 and cnt_both, each CNT_W bits, increment on the same edge that registers the rise pulse.
  - cnt_both increments only when both channels' rise_c are true in the same cycle.
  - On a coincident rise, cnt_p1 and cnt_p2 also increment.
- Saturation: a counter at 2^CNT_W-1 holds its value on an increment. The increment attempt sets that channel's sticky ovf flag. No wrap-around.
- Snapshot FSM, states IDLE and HOLD:
  - IDLE, snap_req=1: at the next edge, capture cnt_p1/cnt_p2/cnt_both/ovf into the snapshot registers using their pre-edge values. Go to HOLD; snap_valid=1 from the following cycle.
  - IDLE, snap_ack=1: ignored.
  - HOLD: snap_req is ignored and the snapshot registers are frozen. snap_ack=1 => next edge returns to IDLE with snap_valid=0. Snapshot data registers retain their values.
  - snap_req and snap_ack both high in HOLD: the ack is honoured and the req is dropped. No back-to-back capture; the host must re-request from IDLE.
- Clear on snapshot (CLR_ON_SNAP=1): on the capture edge each counter loads 1 if its increment condition is true that cycle, else 0, so no edge is lost. Overflow flags clear, unless an increment at max occurs on that same edge.
- No clear (CLR_ON_SNAP=0): counters and flags run continuously. They are cleared only by reset.
- Latency: input edge to pulse and count update is SYNC_STAGES+1 edges. snap_req to snap_valid is 1 edge. snap_ack to snap_valid low is 1 edge.

Test Plan:
- Reset state: with rst_n=0 mid-HOLD and p1y=1, all outputs are 0 at once; after release, the rise is detected once, and p1_rise pulses in cycle 3 (SYNC_STAGES=2).
- Three p1y pulses and two p2y pulses, 4 cycles each, non-overlapping; then snap_req for 1 cycle -> snap_valid=1 next cycle, snap_p1=3, snap_p2=2, snap_both=0, snap_ovf=0; with CLR_ON_SNAP=1 the live counts return to 0.
- p1y and p2y rise on the same clk edge, 5 times -> snap_p1=5, snap_p2=5, snap_both=5.
- CNT_W=4, 17 p1y rises -> snap_p1=15, snap_ovf=3'b001; the next snapshot after clear reads 0 and 3'b000.
- A p2 rise_c true on the capture edge with CLR_ON_SNAP=1 -> snap_p2 holds the old value, the live count is 1, and the second snapshot reads 1.
- snap_req held high through HOLD, then snap_ack with snap_req=1 -> exactly one capture, snap_valid low one edge after ack, and no recapture until snap_req is seen again in IDLE.
